// File: rtl/prbs31_burst_ctrl.sv
// ============================================================================
// Module   : prbs31_burst_ctrl
// Purpose  : Burst sequencer for a PRBS31 32-bit parallel generator.
//            It holds a programmable seed and burst length. On start it
//            steps the generator once per word for LEN words. Each word is
//            serialised MSB byte first onto an 8-bit valid/ready stream.
// Ports    : clk, rst_n      - clock; synchronous active-high reset
//                              (rst_n = 1 resets; name kept for pinout)
//            cfg_we/addr/wdata - byte config writes: 0-3 seed (LE),
//                              4-5 burst length (LE), 6-7 ignored
//            start, abort    - begin burst / terminate burst
//            out_data/valid/ready - byte stream, registered outputs
//            busy, done, word_cnt - status: in RUN, completion pulse,
//                              words fully transferred in this/last burst
// Options  : PRBS_ZERO_GUARD_EN - replace an all-zero seed with 1 at start
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs31_burst_ctrl #(
    parameter int          LEN_W    = 16,
    parameter logic [31:0] SEED_RST = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    input  logic             start,
    input  logic             abort,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] word_cnt
);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_RUN  = 2'd1,
        c_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] c_CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_seed, w_seed_nxt, w_seed_wr, w_seed_eff;
    logic [LEN_W-1:0] r_len, w_len_nxt, w_len_wr, w_len_m1;
    logic [31:0]      r_word, w_word_nxt;
    logic [1:0]       r_byte_idx, w_byte_nxt;
    logic [LEN_W-1:0] r_word_cnt, w_cnt_nxt;
    logic [7:0]       r_out_data, w_out_data_nxt;
    logic             w_hs;
    logic             w_last_word;

    // One parallel step of the PRBS31 generator (32 serial shifts folded).
    function automatic logic [31:0] prbs_step(input logic [31:0] w);
        logic [31:0] nx;
        nx[31:4] = w[30:3] ^ w[27:0];
        nx[3:1]  = w[2:0] ^ w[30:28] ^ w[27:25];
        nx[0]    = w[30] ^ w[24];
        return nx;
    endfunction

    // Config-bus view of seed and length after applying the addressed byte.
    always_comb begin
        w_seed_wr = r_seed;
        case (cfg_addr)
            3'd0:    w_seed_wr[7:0]   = cfg_wdata;
            3'd1:    w_seed_wr[15:8]  = cfg_wdata;
            3'd2:    w_seed_wr[23:16] = cfg_wdata;
            3'd3:    w_seed_wr[31:24] = cfg_wdata;
            default: w_seed_wr = r_seed;
        endcase

        // Length bits 0-7 come from address 4, bits 8 and up from address 5.
        // Written bit by bit so that narrow LEN_W values need no special case.
        w_len_wr = r_len;
        for (int i = 0; i < LEN_W; i++) begin
            if (i < 8) begin
                if (cfg_addr == 3'd4) w_len_wr[i] = cfg_wdata[i[2:0]];
            end else begin
                if (cfg_addr == 3'd5) w_len_wr[i] = cfg_wdata[i[2:0]];
            end
        end
    end

`ifdef PRBS_ZERO_GUARD_EN
    assign w_seed_eff = (r_seed == 32'h0) ? 32'h0000_0001 : r_seed;
`else
    assign w_seed_eff = r_seed;
`endif

    // len cannot change while running and a burst only starts with len != 0,
    // so len-1 never underflows while it matters and the counter never wraps.
    assign w_len_m1    = r_len - c_CNT_ONE;
    assign w_last_word = (r_word_cnt == w_len_m1);
    assign w_hs        = (r_state == c_RUN) && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_seed_nxt  = r_seed;
        w_len_nxt   = r_len;
        w_word_nxt  = r_word;
        w_byte_nxt  = r_byte_idx;
        w_cnt_nxt   = r_word_cnt;

        case (r_state)
            c_IDLE: begin
                if (cfg_we) begin
                    w_seed_nxt = w_seed_wr;
                    w_len_nxt  = w_len_wr;
                end
                if (start) begin
                    w_cnt_nxt = '0;
                    if (r_len != '0) begin
                        w_word_nxt  = prbs_step(w_seed_eff);
                        w_byte_nxt  = 2'd0;
                        w_state_nxt = c_RUN;
                    end else begin
                        w_state_nxt = c_DONE;
                    end
                end
            end

            c_RUN: begin
                if (w_hs) begin
                    if (r_byte_idx != 2'd3) begin
                        w_byte_nxt = r_byte_idx + 2'd1;
                    end else begin
                        w_cnt_nxt = r_word_cnt + c_CNT_ONE;
                        if (w_last_word) begin
                            w_state_nxt = c_DONE;
                        end else begin
                            // Load the next word at once: no bubble on the stream.
                            w_word_nxt = prbs_step(r_word);
                            w_byte_nxt = 2'd0;
                        end
                    end
                end
                // Abort wins over completion; a handshake in this cycle still counts.
                if (abort) w_state_nxt = c_IDLE;
            end

            c_DONE: begin
                w_state_nxt = c_IDLE;
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        w_out_data_nxt = 8'h00;
        if (w_state_nxt == c_RUN) begin
            case (w_byte_nxt)
                2'd0:    w_out_data_nxt = w_word_nxt[31:24];
                2'd1:    w_out_data_nxt = w_word_nxt[23:16];
                2'd2:    w_out_data_nxt = w_word_nxt[15:8];
                default: w_out_data_nxt = w_word_nxt[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= c_IDLE;
            r_seed     <= SEED_RST;
            r_len      <= '0;
            r_word     <= '0;
            r_byte_idx <= 2'd0;
            r_word_cnt <= '0;
            r_out_data <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_seed     <= w_seed_nxt;
            r_len      <= w_len_nxt;
            r_word     <= w_word_nxt;
            r_byte_idx <= w_byte_nxt;
            r_word_cnt <= w_cnt_nxt;
            r_out_data <= w_out_data_nxt;
        end
    end

    // All status outputs decode directly from flops.
    assign out_data  = r_out_data;
    assign out_valid = (r_state == c_RUN);
    assign busy      = (r_state == c_RUN);
    assign done      = (r_state == c_DONE);
    assign word_cnt  = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prbs31_burst_ctrl.sv
// ============================================================================
// Module   : tb_prbs31_burst_ctrl
// Purpose  : Directed self-checking bench for prbs31_burst_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prbs31_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        start;
    logic        abort;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] word_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] cap [0:15];
    int         cap_n;
    int         cyc;
    int         stall_err;

    // Hand-derived: step(1) = 0x00000012, step(0x12) = 0x00000104.
    logic [7:0] exp_seed1 [0:7] = '{8'h00, 8'h00, 8'h00, 8'h12,
                                    8'h00, 8'h00, 8'h01, 8'h04};

    always #5 clk = ~clk;

    prbs31_burst_ctrl #(.LEN_W(16), .SEED_RST(32'h0000_0001)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .start     (start),
        .abort     (abort),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic set_seed(input logic [31:0] s);
        for (int i = 0; i < 4; i++) cfg_write(3'(i), s[8*i +: 8]);
    endtask

    task automatic set_len(input logic [15:0] l);
        cfg_write(3'd4, l[7:0]);
        cfg_write(3'd5, l[15:8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Accept n bytes; toggle=1 alternates ready 1/0. Records stall instability.
    task automatic collect(input int n, input bit toggle);
        logic       pv, pr, ph;
        logic [7:0] pd;
        pv = 1'b0; pr = 1'b1; pd = 8'h00; ph = 1'b1;
        cap_n = 0; cyc = 0; stall_err = 0;
        while (cap_n < n && cyc < 200) begin
            out_ready = toggle ? ph : 1'b1;
            ph = ~ph;
            if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) stall_err++;
            if (out_valid === 1'b1 && out_ready && cap_n < 16) begin
                cap[cap_n] = out_data;
                cap_n++;
            end
            pv = out_valid; pr = out_ready; pd = out_data;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 8'h00;
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", word_cnt); end
    endtask

    task automatic test_basic();
        tick();
        set_seed(32'h0000_0001);
        set_len(16'd2);
        pulse_start();
        total++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
            bad++; $display("FAIL basic_latency busy=%b valid=%b exp=1/1", busy, out_valid);
        end
        collect(8, 1'b0);
        total++; if (cap_n !== 8) begin bad++; $display("FAIL basic_count got=%0d exp=8", cap_n); end
        for (int i = 0; i < 8; i++) begin
            total++; if (cap[i] !== exp_seed1[i]) begin
                bad++; $display("FAIL basic_byte%0d got=%h exp=%h", i, cap[i], exp_seed1[i]);
            end
        end
        total++; if (cyc !== 8) begin bad++; $display("FAIL basic_nobubble cycles=%0d exp=8", cyc); end
        total++; if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_done done=%b valid=%b exp=1/0", done, out_valid);
        end
        total++; if (word_cnt !== 16'd2) begin bad++; $display("FAIL basic_cnt got=%0d exp=2", word_cnt); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_done_pulse done=%b busy=%b exp=0/0", done, busy);
        end
    endtask

    task automatic test_stall();
        tick();
        pulse_start();
        collect(8, 1'b1);
        total++; if (cap_n !== 8) begin bad++; $display("FAIL stall_count got=%0d exp=8", cap_n); end
        for (int i = 0; i < 8; i++) begin
            total++; if (cap[i] !== exp_seed1[i]) begin
                bad++; $display("FAIL stall_byte%0d got=%h exp=%h", i, cap[i], exp_seed1[i]);
            end
        end
        total++; if (stall_err !== 0) begin bad++; $display("FAIL stall_stable errors=%0d exp=0", stall_err); end
        total++; if (done !== 1'b1 || word_cnt !== 16'd2) begin
            bad++; $display("FAIL stall_done done=%b cnt=%0d exp=1/2", done, word_cnt);
        end
        tick();
    endtask

    task automatic test_len_zero();
        tick();
        set_len(16'd0);
        pulse_start();
        total++; if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL len0_done done=%b valid=%b exp=1/0", done, out_valid);
        end
        total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL len0_cnt got=%0d exp=0", word_cnt); end
        tick();
        total++; if (done !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL len0_after done=%b valid=%b exp=0/0", done, out_valid);
        end
    endtask

    task automatic test_abort();
        tick();
        set_seed(32'h0000_0001);
        set_len(16'd5);
        pulse_start();
        collect(6, 1'b0);
        abort = 1'b1; out_ready = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        total++; if (cap[5] !== 8'h00 || cap[3] !== 8'h12) begin
            bad++; $display("FAIL abort_bytes b3=%h b5=%h exp=12/00", cap[3], cap[5]);
        end
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_state valid=%b busy=%b done=%b exp=0/0/0", out_valid, busy, done);
        end
        total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL abort_cnt got=%0d exp=1", word_cnt); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_nodone got=%b exp=0", done); end
    endtask

    task automatic test_abort_byte3();
        tick();
        pulse_start();
        collect(3, 1'b0);
        abort = 1'b1; out_ready = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL abort_b3_cnt got=%0d exp=1", word_cnt); end
        total++; if (out_valid !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_b3_state valid=%b done=%b exp=0/0", out_valid, done);
        end
    endtask

    task automatic test_zero_seed();
        logic [7:0] last;
`ifdef PRBS_ZERO_GUARD_EN
        last = 8'h12;
`else
        last = 8'h00;
`endif
        tick();
        set_seed(32'h0000_0000);
        set_len(16'd1);
        pulse_start();
        collect(4, 1'b0);
        total++; if (cap_n !== 4) begin bad++; $display("FAIL zseed_count got=%0d exp=4", cap_n); end
        total++; if (cap[0] !== 8'h00 || cap[1] !== 8'h00 || cap[2] !== 8'h00 || cap[3] !== last) begin
            bad++; $display("FAIL zseed_bytes got=%h%h%h%h exp=000000%h", cap[0], cap[1], cap[2], cap[3], last);
        end
        total++; if (done !== 1'b1 || word_cnt !== 16'd1) begin
            bad++; $display("FAIL zseed_done done=%b cnt=%0d exp=1/1", done, word_cnt);
        end
        tick();
    endtask

    task automatic test_cfg_busy();
        tick();
        set_seed(32'h0000_0001);
        set_len(16'd2);
        pulse_start();
        set_seed(32'hFFFF_FFFF);
        set_len(16'd7);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL cfgbusy_run got=%b exp=1", busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pulse_start();
        collect(8, 1'b0);
        total++; if (cap_n !== 8) begin bad++; $display("FAIL cfgbusy_count got=%0d exp=8", cap_n); end
        for (int i = 0; i < 8; i++) begin
            total++; if (cap[i] !== exp_seed1[i]) begin
                bad++; $display("FAIL cfgbusy_byte%0d got=%h exp=%h", i, cap[i], exp_seed1[i]);
            end
        end
        total++; if (done !== 1'b1 || word_cnt !== 16'd2) begin
            bad++; $display("FAIL cfgbusy_done done=%b cnt=%0d exp=1/2", done, word_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        tick();
        set_seed(32'hFFFF_FFFF);
        set_len(16'd3);
        pulse_start();
        collect(3, 1'b0);
        // step(0xFFFFFFFF) = 0x0000000E, so byte 3 is on the bus now.
        total++; if (out_data !== 8'h0E) begin bad++; $display("FAIL rstmid_pre got=%h exp=0e", out_data); end
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || word_cnt !== 16'd0) begin
            bad++; $display("FAIL rstmid_outputs valid=%b data=%h busy=%b done=%b cnt=%0d exp=0/00/0/0/0",
                            out_valid, out_data, busy, done, word_cnt);
        end
        rst_n = 1'b0; out_ready = 1'b0;
        tick();
        pulse_start();
        total++; if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_len0 done=%b valid=%b exp=1/0", done, out_valid);
        end
        tick();
        set_len(16'd1);
        pulse_start();
        collect(4, 1'b0);
        total++; if (cap_n !== 4 || cap[0] !== 8'h00 || cap[1] !== 8'h00 || cap[2] !== 8'h00 || cap[3] !== 8'h12) begin
            bad++; $display("FAIL rstmid_seed n=%0d got=%h%h%h%h exp=00000012", cap_n, cap[0], cap[1], cap[2], cap[3]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_len_zero();
        test_abort();
        test_abort_byte3();
        test_zero_seed();
        test_cfg_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
